// File: rtl/sevenseg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_scan_decoder
// Purpose  : Receive end of the multiplexed 4-digit seven-segment bus.
//            Rebuilds the displayed value as four BCD digits plus a
//            decimal-point mask. A settle filter rejects anode-switch
//            glitches. Each completed scan of all four digits publishes
//            one coherent frame, marked by a one-cycle strobe.
// Ports    : clk, reset (async, active-high)
//            seg[6:0] {g,f,e,d,c,b,a} active-low, dp active-low,
//            an[3:0] active-low anodes (an[0] = rightmost digit)
//            digit0..digit3[3:0], dp_mask[3:0], frame_valid,
//            decode_err (sticky), scan_stall (level)
// Params   : SETTLE_CYCLES  (1..255)   identical samples before capture
//            TIMEOUT_CYCLES (1..65535) capture-free cycles before stall
// Options  : define SEVENSEG_SCAN_BLANK_EN to decode the all-off segment
//            pattern as blank (4'hF) instead of an unknown pattern.
// Revision : 1.0 - initial release
// ============================================================================
module sevenseg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg,
    input  logic       dp,
    input  logic [3:0] an,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] dp_mask,
    output logic       frame_valid,
    output logic       decode_err,
    output logic       scan_stall
);

    localparam logic [1:0]  c_idle    = 2'd0;
    localparam logic [1:0]  c_settle  = 2'd1;
    localparam logic [1:0]  c_held    = 2'd2;
    localparam logic [7:0]  c_settle_target = 8'(SETTLE_CYCLES);
    localparam logic [15:0] c_timeout       = 16'(TIMEOUT_CYCLES);

    logic [1:0]  r_state;
    logic [7:0]  r_count;
    logic [11:0] r_prev;
    logic [3:0]  r_slot [4];
    logic [3:0]  r_slot_dp;
    logic [3:0]  r_capture_mask;
    logic [15:0] r_stall_cnt;

    logic [11:0] w_sample;
    logic        w_same;
    logic        w_anode_valid;
    logic [1:0]  w_idx;
    logic [3:0]  w_code;
    logic        w_unknown;
    logic [1:0]  w_state_next;
    logic [7:0]  w_count_next;
    logic        w_evaluate;
    logic        w_capture;
    logic [3:0]  w_cap_bit;
    logic [3:0]  w_mask_next;
    logic        w_frame_done;
    logic [3:0]  w_slot_next [4];
    logic [3:0]  w_slot_dp_next;

    assign w_sample = {an, seg, dp};
    assign w_same   = (w_sample == r_prev);

    // Exactly one anode low selects a digit; anything else is a blanking gap.
    always_comb begin
        w_anode_valid = 1'b1;
        w_idx         = 2'd0;
        case (an)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_anode_valid = 1'b0;
        endcase
    end

    // Active-low {g,f,e,d,c,b,a} to BCD.
    always_comb begin
        w_code    = 4'hE;
        w_unknown = 1'b0;
        case (seg)
            7'b1000000: w_code = 4'd0;
            7'b1111001: w_code = 4'd1;
            7'b0100100: w_code = 4'd2;
            7'b0110000: w_code = 4'd3;
            7'b0011001: w_code = 4'd4;
            7'b0010010: w_code = 4'd5;
            7'b0000010: w_code = 4'd6;
            7'b1111000: w_code = 4'd7;
            7'b0000000: w_code = 4'd8;
            7'b0010000: w_code = 4'd9;
`ifdef SEVENSEG_SCAN_BLANK_EN
            7'b1111111: w_code = 4'hF;
`endif
            default: begin
                w_code    = 4'hE;
                w_unknown = 1'b1;
            end
        endcase
    end

    // Settle filter. w_evaluate marks cycles where the new count is compared
    // against the target, so capture lands on the edge that completes the
    // run of identical samples (SETTLE_CYCLES = 1 captures immediately).
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_evaluate   = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_anode_valid) begin
                    w_count_next = 8'd1;
                    w_evaluate   = 1'b1;
                end
            end
            c_settle: begin
                if (!w_anode_valid) begin
                    w_state_next = c_idle;
                    w_count_next = 8'd0;
                end else begin
                    w_count_next = w_same ? (r_count + 8'd1) : 8'd1;
                    w_evaluate   = 1'b1;
                end
            end
            c_held: begin
                if (!w_anode_valid) begin
                    w_state_next = c_idle;
                    w_count_next = 8'd0;
                end else if (!w_same) begin
                    w_count_next = 8'd1;
                    w_evaluate   = 1'b1;
                end
            end
            default: begin
                w_state_next = c_idle;
                w_count_next = 8'd0;
            end
        endcase
        w_capture = w_evaluate && (w_count_next == c_settle_target);
        if (w_evaluate) begin
            w_state_next = w_capture ? c_held : c_settle;
        end
    end

    // Staging slots after this cycle's capture, so a frame that completes on
    // this edge publishes the digit captured on this same edge.
    always_comb begin
        w_cap_bit      = w_capture ? (4'b0001 << w_idx) : 4'b0000;
        w_mask_next    = r_capture_mask | w_cap_bit;
        w_frame_done   = (w_mask_next == 4'b1111);
        w_slot_dp_next = r_slot_dp;
        for (int j = 0; j < 4; j++) begin
            w_slot_next[j] = r_slot[j];
            if (w_cap_bit[j]) begin
                w_slot_next[j]    = w_code;
                w_slot_dp_next[j] = ~dp;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= c_idle;
            r_count        <= 8'd0;
            r_prev         <= 12'd0;
            r_slot_dp      <= 4'd0;
            r_capture_mask <= 4'd0;
            r_stall_cnt    <= 16'd0;
            for (int j = 0; j < 4; j++) begin
                r_slot[j] <= 4'd0;
            end
            digit0         <= 4'd0;
            digit1         <= 4'd0;
            digit2         <= 4'd0;
            digit3         <= 4'd0;
            dp_mask        <= 4'd0;
            frame_valid    <= 1'b0;
            decode_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_prev    <= w_sample;
            r_slot_dp <= w_slot_dp_next;
            for (int j = 0; j < 4; j++) begin
                r_slot[j] <= w_slot_next[j];
            end
            r_capture_mask <= w_frame_done ? 4'd0 : w_mask_next;
            frame_valid    <= w_frame_done;
            if (w_frame_done) begin
                digit0  <= w_slot_next[0];
                digit1  <= w_slot_next[1];
                digit2  <= w_slot_next[2];
                digit3  <= w_slot_next[3];
                dp_mask <= w_slot_dp_next;
            end
            if (w_capture && w_unknown) begin
                decode_err <= 1'b1;
            end
            if (w_capture) begin
                r_stall_cnt <= 16'd0;
            end else if (r_stall_cnt != c_timeout) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign scan_stall = (r_stall_cnt == c_timeout);

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sevenseg_scan_decoder
// Purpose  : Directed self-checking bench for sevenseg_scan_decoder.
//            Drives clean, glitched, erroneous and interrupted scans and
//            checks published values, strobe timing, sticky error and
//            stall behaviour against hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sevenseg_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 40;

    localparam logic [3:0] AN0 = 4'b1110;
    localparam logic [3:0] AN1 = 4'b1101;
    localparam logic [3:0] AN2 = 4'b1011;
    localparam logic [3:0] AN3 = 4'b0111;
    localparam logic [3:0] ANX = 4'b1111;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P6 = 7'b0000010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] PBAD   = 7'b0101010;
    localparam logic [6:0] PBLANK = 7'b1111111;

`ifdef SEVENSEG_SCAN_BLANK_EN
    localparam logic [3:0] BLANK_CODE = 4'hF;
`else
    localparam logic [3:0] BLANK_CODE = 4'hE;
`endif

    logic       clk;
    logic       reset;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [3:0] dp_mask;
    logic       frame_valid;
    logic       decode_err;
    logic       scan_stall;

    int checks = 0;
    int errors = 0;

    sevenseg_scan_decoder #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .dp_mask    (dp_mask),
        .frame_valid(frame_valid),
        .decode_err (decode_err),
        .scan_stall (scan_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d);
        an  = a;
        seg = s;
        dp  = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One digit held for the full 8-cycle anode slot.
    task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d);
        drive(a, s, d);
        tick(8);
    endtask

    // Glitch anode pattern (two anodes low) for two cycles.
    task automatic glitch();
        drive(4'b1100, P8, 1'b1);
        tick(2);
    endtask

    // Frame-completing digit: strobe must appear exactly SETTLE edges after
    // the sample is first presented. Leaves time 1 unit after that edge.
    task automatic last_digit(input string tag, input logic [3:0] a,
                              input logic [6:0] s, input logic d);
        drive(a, s, d);
        tick(SETTLE - 1);
        chk({tag, "_fv_early"}, frame_valid, 1'b0);
        tick(1);
        chk({tag, "_fv_pulse"}, frame_valid, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        drive(ANX, PBLANK, 1'b1);

        // Reset held while inputs toggle.
        tick(1);
        drive(AN0, P8, 1'b0);
        tick(SETTLE + 1);
        drive(AN3, P1, 1'b1);
        tick(SETTLE + 1);
        chk("rst_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
        chk("rst_dp_mask", dp_mask, 4'h0);
        chk("rst_flags", {frame_valid, decode_err, scan_stall}, 3'b000);
        drive(ANX, PBLANK, 1'b1);
        reset = 1'b0;
        tick(2);

        // Clean scan "12.34".
        hold(AN3, P1, 1'b1);
        hold(AN2, P2, 1'b0);
        hold(AN1, P3, 1'b1);
        chk("clean_no_early_fv", frame_valid, 1'b0);
        chk("clean_no_early_pub", {digit3, digit2, digit1, digit0}, 16'h0000);
        last_digit("clean", AN0, P4, 1'b1);
        chk("clean_digits", {digit3, digit2, digit1, digit0}, 16'h1234);
        chk("clean_dp_mask", dp_mask, 4'b0100);
        tick(1);
        chk("clean_fv_one_cycle", frame_valid, 1'b0);
        tick(3);

        // Same scan with two-anode glitches between digits.
        hold(AN3, P1, 1'b1);
        glitch();
        hold(AN2, P2, 1'b0);
        glitch();
        hold(AN1, P3, 1'b1);
        glitch();
        last_digit("glitch", AN0, P4, 1'b1);
        chk("glitch_digits", {digit3, digit2, digit1, digit0}, 16'h1234);
        chk("glitch_dp_mask", dp_mask, 4'b0100);
        tick(4);

        // Unknown pattern on an[1] and the all-off pattern on an[0].
        hold(AN3, P5, 1'b1);
        hold(AN2, P6, 1'b1);
        chk("err_clear_before", decode_err, 1'b0);
        drive(AN1, PBAD, 1'b1);
        tick(SETTLE - 1);
        chk("err_not_before_capture", decode_err, 1'b0);
        tick(1);
        chk("err_set_on_capture", decode_err, 1'b1);
        tick(4);
        last_digit("err", AN0, PBLANK, 1'b1);
        chk("err_digits", {digit3, digit2, digit1, digit0}, {12'h56E, BLANK_CODE});
        chk("err_dp_mask", dp_mask, 4'b0000);
        tick(4);

        // Clean scan afterwards: error stays sticky, digits refresh.
        hold(AN3, P7, 1'b1);
        hold(AN2, P8, 1'b1);
        hold(AN1, P9, 1'b1);
        last_digit("sticky", AN0, P0, 1'b1);
        chk("sticky_digits", {digit3, digit2, digit1, digit0}, 16'h7890);
        chk("sticky_err", decode_err, 1'b1);
        tick(4);

        // Asynchronous reset clears published state without a clock edge.
        drive(ANX, PBLANK, 1'b1);
        reset = 1'b1;
        #1;
        chk("async_rst_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
        chk("async_rst_err", decode_err, 1'b0);
        reset = 1'b0;

        // Stall: blanked bus for exactly TIMEOUT edges.
        tick(TIMEOUT - 1);
        chk("stall_before_timeout", scan_stall, 1'b0);
        tick(1);
        chk("stall_at_timeout", scan_stall, 1'b1);
        tick(5);
        chk("stall_saturated", scan_stall, 1'b1);
        drive(AN0, P4, 1'b1);
        tick(SETTLE - 1);
        chk("stall_before_capture", scan_stall, 1'b1);
        tick(1);
        chk("stall_drop_after_capture", scan_stall, 1'b0);
        tick(4);

        // Reset after two captures discards the partial frame.
        hold(AN3, P9, 1'b1);
        hold(AN2, P1, 1'b0);
        reset = 1'b1;
        #2;
        chk("midrst_fv", frame_valid, 1'b0);
        reset = 1'b0;
        hold(AN1, P5, 1'b1);
        drive(AN0, P2, 1'b1);
        tick(SETTLE);
        chk("midrst_partial_discarded", frame_valid, 1'b0);
        chk("midrst_no_publish", {digit3, digit2, digit1, digit0, dp_mask}, 20'h0);
        tick(4);
        hold(AN3, P4, 1'b1);
        last_digit("midrst", AN2, P7, 1'b1);
        chk("midrst_digits", {digit3, digit2, digit1, digit0}, 16'h4752);
        chk("midrst_dp_mask", dp_mask, 4'b0000);
        tick(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sevenseg_scan_decoder.md
# sevenseg_scan_decoder

Reads the multiplexed 4-digit seven-segment bus (active-low `seg`, `dp` and `an`) driven by the timer top and reconstructs the displayed value as four BCD digits plus a decimal-point mask. It is the receive end of the display interface. It sits beside the timer in self-checking benches and in the on-board readback/debug path. A settle filter rejects anode-switch glitches, and a completed scan of all four digits publishes one coherent frame with a one-cycle strobe.

## Interface
- `SETTLE_CYCLES`, default 4: consecutive identical samples required before a digit is captured (range 1–255).
- `TIMEOUT_CYCLES`, default 65535: cycles without any capture before `scan_stall` asserts (range 1–65535).
- `clk` in 1: system clock (100 MHz); all logic on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `seg` in 7: segment cathodes, active-low, bit order `{g,f,e,d,c,b,a}`.
- `dp` in 1: decimal point, active-low.
- `an` in 4: digit anodes, active-low; `an[0]` is the rightmost digit.
- `digit0`..`digit3` out 4 each: published BCD digits; the index matches the anode bit.
- `dp_mask` out 4: published decimal-point states; bit i = 1 when the point is lit on digit i.
- `frame_valid` out 1: one-cycle pulse when new `digit*`/`dp_mask` values are published.
- `decode_err` out 1: sticky; set by any captured unknown segment pattern.
- `scan_stall` out 1: level; no capture for `TIMEOUT_CYCLES` cycles.

## Operation
- Inputs come from the same clock domain and are sampled directly, with no synchronizer.
- The sample is valid only when `an` has exactly one bit low. Any other value is a blanking gap.
- Decode table, active-low `gfedcba`:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- States:
  - IDLE: no valid anode.
  - SETTLE: valid anode; counting identical samples of `{an,seg,dp}`.
  - HELD: digit captured; waiting for `{an,seg,dp}` to change.
- Transitions:
  - IDLE → SETTLE on a valid anode; count = 1.
  - SETTLE stays in SETTLE, count incremented, while `{an,seg,dp}` is unchanged.
  - SETTLE restarts at count = 1 on any change to another valid sample.
  - SETTLE → IDLE on a blanking gap.
  - When count reaches `SETTLE_CYCLES`: capture, then → HELD.
  - HELD → SETTLE (count = 1) on a change to another valid sample.
  - HELD → IDLE on a blanking gap.
- Capture action:
  - Write the decoded BCD and `~dp` into staging slot i.
  - Set `capture_mask[i]`.
  - Reset the stall counter.
  - If the pattern is unknown: store 4'hE in the slot and set `decode_err`.
- Re-capturing slot i before the frame completes overwrites the slot. The mask bit stays set.
- Frame completion: when `capture_mask == 4'b1111`:
  - copy the staging slots to the `digit*`/`dp_mask` outputs,
  - pulse `frame_valid`,
  - clear `capture_mask`.
- Stall counter:
  - 16-bit, increments every cycle without a capture and saturates at `TIMEOUT_CYCLES`.
  - `scan_stall` = (counter == `TIMEOUT_CYCLES`).
  - Any capture clears the counter and drops `scan_stall` the next cycle.
- `decode_err` clears only on reset.

## Timing
- Reset values:
  - `digit*` = 0, `dp_mask` = 0, `frame_valid` = 0, `decode_err` = 0, `scan_stall` = 0.
  - state IDLE, count = 0, `capture_mask` = 0, stall counter = 0.
- Capture latency: with a valid, stable sample first present at edge N, capture happens at edge N + `SETTLE_CYCLES` − 1.
- Publish latency: `frame_valid` is high and `digit*` are updated in the cycle after the capture that completes the mask.
- Capture and frame completion in the same cycle as a new sample change: the change is evaluated as the next sample and is not lost.
- `SETTLE_CYCLES` = 1: capture in the first valid cycle, then HELD.
- Reset mid-frame: the partial frame is discarded. Published outputs return to 0 asynchronously.

## Configuration
- `SEVENSEG_SCAN_BLANK_EN`:
  - Defined: all segments off (7'b1111111) on a valid anode decodes as blank. The slot stores 4'hF, and `decode_err` is not set.
  - Undefined: the same pattern is an unknown pattern. The slot stores 4'hE, and `decode_err` is set.

## Test plan
- Reset asserted while inputs toggle: all outputs 0 and no `frame_valid` until 4 digits have been captured after release.
- Scan "12.34" (each anode held 8 cycles, dp lit on `an[2]`, `SETTLE_CYCLES`=4) → `digit3..0` = 1,2,3,4, `dp_mask` = 4'b0100, `frame_valid` one cycle after the `an[0]` capture.
- A 2-cycle glitch `an` = 4'b1100 between digits → treated as a gap; values and latency unchanged from the clean scan.
- `seg` = 7'b0101010 on `an[1]` → `decode_err` = 1 and sticky, `digit1` = 4'hE after the frame; blank pattern gives 4'hF or 4'hE depending on the macro.
- `an` held at 4'b1111 for `TIMEOUT_CYCLES` → `scan_stall` = 1 exactly at the count; drops one cycle after the next capture.
- Reset pulsed after 2 of 4 captures → no `frame_valid`; the next full scan publishes only the new values.
